zoom_hdmi_fifo_reader: RTL
==========================

Name: zoom_hdmi_fifo_reader

Overview:
Read-side consumer of the 24-bit, 256-deep zoom→HDMI asynchronous pixel FIFO, in the HDMI pixel-clock domain. Pulls one pixel per active-video cycle from the timing generator and compensates the FIFO's registered read latency. Outputs HDMI-ready sync/DE/RGB aligned to the data. Primes at each frame start and substitutes a fill colour on underflow, so timing to the HDMI encoder is never disturbed.

Parameters:
DATA_WIDTH, 24, pixel width; equals the FIFO read-data width.
RD_LATENCY, 2, rd_en→rd_data cycles (FIFO built with output register); legal values 1 or 2.
VS_POL, 1, active level of vid_vs_i (1 = active-high).
FILL_COLOR, 24'h000000, pixel driven when no FIFO data is available.
UF_CNT_WIDTH, 16, underflow counter width.

Ports:
rd_clk  in  1  pixel clock; also the FIFO rd_clk.
rd_rst  in  1  synchronous, active-high reset.
vid_vs_i  in  1  vsync from timing generator.
vid_hs_i  in  1  hsync from timing generator.
vid_de_i  in  1  active-video enable from timing generator.
fifo_rd_en  out  1  FIFO read strobe.
fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after rd_en.
fifo_rd_empty  in  1  FIFO empty.
fifo_almost_empty  in  1  FIFO almost-empty (threshold 4).
vid_vs_o  out  1  vsync delayed RD_LATENCY.
vid_hs_o  out  1  hsync delayed RD_LATENCY.
vid_de_o  out  1  DE delayed RD_LATENCY.
vid_rgb_o  out  DATA_WIDTH  pixel; 0 when vid_de_o=0.
underflow_o  out  1  sticky per-frame underflow flag.
underflow_cnt_o  out  UF_CNT_WIDTH  saturating count of starved pixels since reset.
running_o  out  1  high in state RUN.

Behaviour:
- Reset (rd_rst=1 at rd_clk edge): state IDLE; all delay pipes cleared. Every output is 0 (rgb 0, cnt 0, flags 0). fifo_rd_en forced 0 in the same cycle rd_rst is high.
- vs_start = vid_vs_i at its active level while the registered previous vs is inactive (one-cycle pulse).
- FSM:
  - IDLE → PRIME on vs_start.
  - PRIME → RUN when fifo_almost_empty=0 and vid_de_i=0. Never enters RUN mid-line.
  - RUN → PRIME on vs_start. This re-primes every frame.
  - No other transitions; rd_rst returns to IDLE from any state.
- fifo_rd_en = (state==RUN) & vid_de_i & ~fifo_rd_empty. This is combinational from registered state and inputs.
- Pixel pipe: vs/hs/de and a tag bit rd_tag = fifo_rd_en are each shifted through RD_LATENCY registers.
- At pipe output:
  - vid_rgb_o = de_d ? (tag_d ? fifo_rd_data : FILL_COLOR) : 0.
  - vid_rgb_o is registered together with the delayed syncs, so all four video outputs change on the same edge.
- Total input→output latency is exactly RD_LATENCY cycles for sync/DE.
- DE outside RUN (IDLE/PRIME): FILL_COLOR pixels; not counted as underflow; no reads.
- Underflow event: state==RUN & vid_de_i & fifo_rd_empty in a cycle.
  - Sets underflow_o the next cycle.
  - Increments underflow_cnt_o by 1, saturating at all-ones (no wrap).
- underflow_o clears on vs_start, unless an underflow event occurs in that same cycle; the set has priority.
- Simultaneous vs_start and DE in RUN: the read for that cycle is still issued (state changes at the edge). The pixel's tag travels with it.
- The block never reads while empty and never stalls DE. Surplus data at frame end stays in the FIFO; the writer owns frame alignment.

Decomposition:
- Package zoom_hdmi_pkg: DATA_WIDTH default, FILL_COLOR default, FSM state enum {IDLE, PRIME, RUN} as 2-bit localparams.
- One natural sub-module: zoom_hdmi_delay_pipe. This is a parameterised N-stage, W-bit shift register with synchronous reset, instanced for {vs,hs,de,tag}. The FSM, read logic, and counters stay in the top module.

Test Plan:
- Reset mid-line: drive DE=1 in RUN, assert rd_rst for 3 cycles.
  - fifo_rd_en=0 during reset.
  - All outputs 0 one cycle after the first reset edge.
  - state IDLE; a new vs_start is needed before any read.
- Priming: vs pulse, almost_empty=1 for 20 cycles spanning an 8-pixel DE.
  - No rd_en.
  - vid_de_o high 2 cycles after vid_de_i with rgb=FILL_COLOR.
  - underflow_cnt_o stays 0.
  - RUN entered on the first DE-low cycle after almost_empty falls.
- Normal line: FIFO model preloaded with 24'hFFFFFF down-counting; 8-pixel DE in RUN.
  - Exactly 8 rd_en pulses.
  - vid_rgb_o = FFFFFF…FFFFF8 on the 8 cycles where vid_de_o=1, 2 cycles after DE.
  - hs/vs delayed by 2 cycles.
- Underflow: empty rises at pixel 5 of 8.
  - Pixels 5–8 = FILL_COLOR; rd_en low on those 4 cycles.
  - underflow_o=1; underflow_cnt_o=4.
  - Next vs_start clears underflow_o; the count is retained.
- Saturation: force the counter to 16'hFFFE, then starve 3 pixels → underflow_cnt_o=16'hFFFF, no wrap.
- Edge cases (RD_LATENCY=1 build and VS_POL=0):
  - Same normal-line sequence, with data/DE 1 cycle after input.
  - Active-low vsync correctly triggers PRIME.

Source files
------------

// File: rtl/zoom_hdmi_pkg.sv
// Shared definitions for the zoom->HDMI FIFO read side: defaults and FSM encoding.
package zoom_hdmi_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 24;
   localparam logic [DATA_WIDTH_DEF-1:0] FILL_COLOR_DEF = 24'h000000;

   // Reader FSM: wait for a frame, wait for enough buffered data, stream.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   // True when the raw vsync level matches the configured active polarity.
   function automatic logic vs_active(input logic vs, input logic pol);
      return (vs == pol);
   endfunction

endpackage

// File: rtl/zoom_hdmi_delay_pipe.sv
// N-stage, W-bit shift register with synchronous clear; aligns timing signals
// with FIFO read data that arrives N cycles after the read strobe.
module zoom_hdmi_delay_pipe #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         srst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [N-1:0][W-1:0] stage_q;
   logic [N-1:0][W-1:0] stage_d;

   // Each stage takes the previous one; stage 0 takes the input.
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < N; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Advance the whole pipe every cycle; reset empties it.
   always_ff @(posedge clk) begin
      if (srst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/zoom_hdmi_fifo_reader.sv
// Pixel-clock consumer of the zoom->HDMI async FIFO. Reads one pixel per active
// video cycle, re-primes at each frame start, and substitutes a fill colour when
// the FIFO runs dry so the HDMI timing never stalls.
module zoom_hdmi_fifo_reader
   import zoom_hdmi_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned           RD_LATENCY   = 2,
   parameter bit                    VS_POL       = 1'b1,
   parameter logic [DATA_WIDTH-1:0] FILL_COLOR   = DATA_WIDTH'(FILL_COLOR_DEF),
   parameter int unsigned           UF_CNT_WIDTH = 16
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst,
   input  logic                    vid_vs_i,
   input  logic                    vid_hs_i,
   input  logic                    vid_de_i,
   output logic                    fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
   input  logic                    fifo_rd_empty,
   input  logic                    fifo_almost_empty,
   output logic                    vid_vs_o,
   output logic                    vid_hs_o,
   output logic                    vid_de_o,
   output logic [DATA_WIDTH-1:0]   vid_rgb_o,
   output logic                    underflow_o,
   output logic [UF_CNT_WIDTH-1:0] underflow_cnt_o,
   output logic                    running_o
);

   state_e                  state_q, state_d;
   logic                    running_q, running_d;
   logic                    vs_prev_q, vs_prev_d;
   logic                    uf_q, uf_d;
   logic [UF_CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

   logic vs_act;
   logic vs_start;
   logic in_run;
   logic rd_req;
   logic uf_evt;

   logic de_d, hs_d, vs_d, tag_d;

   assign vs_act   = vs_active(vid_vs_i, VS_POL);
   assign vs_start = vs_act & ~vs_prev_q;
   assign in_run   = (state_q == ST_RUN);

   // Reads only happen while streaming, during active video, with data present.
   assign rd_req = in_run & vid_de_i & ~fifo_rd_empty;
   // A starved pixel: the timing wants a pixel but the FIFO has none.
   assign uf_evt = in_run & vid_de_i & fifo_rd_empty;

   // Reset kills the strobe immediately, not one cycle later.
   assign fifo_rd_en = rd_req & ~rd_rst;

   // Next-state logic: prime on frame start, enter RUN only between lines.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (vs_start) state_d = ST_PRIME;
         ST_PRIME: if (!fifo_almost_empty && !vid_de_i) state_d = ST_RUN;
         ST_RUN:   if (vs_start) state_d = ST_PRIME;
         default:  state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUN);
   end

   // Underflow flag (set wins over frame-start clear) and saturating counter.
   always_comb begin
      vs_prev_d = vs_act;
      uf_d      = uf_q;
      uf_cnt_d  = uf_cnt_q;
      if (uf_evt) begin
         uf_d = 1'b1;
      end else if (vs_start) begin
         uf_d = 1'b0;
      end
      if (uf_evt && (uf_cnt_q != {UF_CNT_WIDTH{1'b1}})) begin
         uf_cnt_d = uf_cnt_q + UF_CNT_WIDTH'(1);
      end
   end

   // State, status and vsync-edge registers.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         vs_prev_q <= 1'b0;
         uf_q      <= 1'b0;
         uf_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         vs_prev_q <= vs_prev_d;
         uf_q      <= uf_d;
         uf_cnt_q  <= uf_cnt_d;
      end
   end

   // Syncs, DE and the "this pixel was read" tag travel together so they line
   // up with fifo_rd_data, which appears RD_LATENCY cycles after the strobe.
   zoom_hdmi_delay_pipe #(
      .N (RD_LATENCY),
      .W (4)
   ) u_pipe (
      .clk  (rd_clk),
      .srst (rd_rst),
      .din  ({vid_vs_i, vid_hs_i, vid_de_i, fifo_rd_en}),
      .dout ({vs_d, hs_d, de_d, tag_d})
   );

   // fifo_rd_data comes straight from the FIFO output register on this clock,
   // so selecting it here changes on the same edge as the delayed syncs.
   always_comb begin
      vid_rgb_o = '0;
      if (de_d) begin
         vid_rgb_o = tag_d ? fifo_rd_data : FILL_COLOR;
      end
   end

   assign vid_vs_o        = vs_d;
   assign vid_hs_o        = hs_d;
   assign vid_de_o        = de_d;
   assign underflow_o     = uf_q;
   assign underflow_cnt_o = uf_cnt_q;
   assign running_o       = running_q;

endmodule
